// File: rtl/ifid_hazard_stage_if.sv
// ----------------------------------------------------------------------------
// ifid_hazard_stage_if
// Groups the signals between the fetch front end and its neighbours: the
// instruction memory, the MEM-stage branch resolution, the ID/EX register and
// the ID stage.
//   master : the environment. It drives instr_in, branch_taken,
//            branch_target, idex_MemRead and idex_rd, and it observes the
//            front-end outputs.
//   slave  : ifid_hazard_stage. It drives PC_out, ifid_PC, ifid_instr,
//            ifid_valid, stall, flush and stall_count.
// ----------------------------------------------------------------------------
interface ifid_hazard_stage_if #(
  parameter int CNT_W = 32
);
  // Environment -> front end
  logic [31:0]      instr_in;
  logic             branch_taken;
  logic [63:0]      branch_target;
  logic             idex_MemRead;
  logic [4:0]       idex_rd;

  // Front end -> environment
  logic [63:0]      PC_out;
  logic [63:0]      ifid_PC;
  logic [31:0]      ifid_instr;
  logic             ifid_valid;
  logic             stall;
  logic             flush;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output instr_in, branch_taken, branch_target, idex_MemRead, idex_rd,
    input  PC_out, ifid_PC, ifid_instr, ifid_valid, stall, flush, stall_count
  );

  modport slave (
    input  instr_in, branch_taken, branch_target, idex_MemRead, idex_rd,
    output PC_out, ifid_PC, ifid_instr, ifid_valid, stall, flush, stall_count
  );
endinterface

// File: rtl/ifid_hazard_stage.sv
// ----------------------------------------------------------------------------
// ifid_hazard_stage
// This is the fetch-side front end of a 5-stage RISC-V pipeline. It holds the
// PC register, the IF/ID pipeline register and the load-use hazard detector.
//   clk    : system clock. All state updates on the rising edge.
//   reset  : synchronous, active-low reset.
//   bus    : ifid_hazard_stage_if.slave
//            in  : instr_in, branch_taken, branch_target, idex_MemRead, idex_rd
//            out : PC_out, ifid_PC, ifid_instr, ifid_valid, stall, flush,
//                  stall_count
// Update priority: a taken branch (flush) comes first, then a load-use stall,
// then a normal sequential fetch.
// ----------------------------------------------------------------------------
module ifid_hazard_stage #(
  parameter logic [63:0] PC_RESET  = 64'h0,
  parameter logic [31:0] NOP_INSTR = 32'h00000013,
  parameter int          CNT_W     = 32
) (
  input  logic               clk,
  input  logic               reset,
  ifid_hazard_stage_if.slave bus
);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;

  logic [63:0]      r_pc;
  logic [63:0]      r_ifid_pc;
  logic [31:0]      r_ifid_instr;
  logic             r_ifid_valid;
  logic [CNT_W-1:0] r_stall_count;

  logic [6:0]       w_opcode;
  logic             w_uses_rs1;
  logic             w_uses_rs2;
  logic             w_hz;

  assign w_opcode = r_ifid_instr[6:0];

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    w_uses_rs1 = 1'b1;
    w_uses_rs2 = 1'b0;
    case (w_opcode)
      OP_LUI, OP_AUIPC, OP_JAL: w_uses_rs1 = 1'b0;
      default:                  w_uses_rs1 = 1'b1;
    endcase
    case (w_opcode)
      OP_R, OP_S, OP_B: w_uses_rs2 = 1'b1;
      default:          w_uses_rs2 = 1'b0;
    endcase
  end

  // A load in ID/EX whose rd feeds a source register of the instruction in
  // IF/ID. A bubble in IF/ID (valid=0) and rd=x0 never count as hazards.
  assign w_hz = bus.idex_MemRead && r_ifid_valid && (bus.idex_rd != 5'd0) &&
                ((w_uses_rs1 && (bus.idex_rd == r_ifid_instr[19:15])) ||
                 (w_uses_rs2 && (bus.idex_rd == r_ifid_instr[24:20])));

  // A taken branch overrides the stall. The instruction that would have
  // stalled is being squashed, so the ID/EX control bits must not be zeroed
  // on its behalf.
  assign bus.stall = w_hz && !bus.branch_taken;
  assign bus.flush = bus.branch_taken;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc          <= PC_RESET;
      r_ifid_pc     <= 64'd0;
      r_ifid_instr  <= NOP_INSTR;
      r_ifid_valid  <= 1'b0;
      r_stall_count <= '0;
    end else if (bus.branch_taken) begin
      // Force word alignment on the redirect target.
      r_pc         <= {bus.branch_target[63:2], 2'b00};
      r_ifid_pc    <= 64'd0;
      r_ifid_instr <= NOP_INSTR;
      r_ifid_valid <= 1'b0;
    end else if (w_hz) begin
      // PC and IF/ID hold. Only the event counter moves, and it saturates.
      if (r_stall_count != '1) begin
        r_stall_count <= r_stall_count + CNT_W'(1);
      end
    end else begin
      r_pc         <= r_pc + 64'd4;
      r_ifid_pc    <= r_pc;
      r_ifid_instr <= bus.instr_in;
      r_ifid_valid <= 1'b1;
    end
  end

  assign bus.PC_out      = r_pc;
  assign bus.ifid_PC     = r_ifid_pc;
  assign bus.ifid_instr  = r_ifid_instr;
  assign bus.ifid_valid  = r_ifid_valid;
  assign bus.stall_count = r_stall_count;

endmodule

// File: tb/tb_ifid_hazard_stage.sv
// ----------------------------------------------------------------------------
// tb_ifid_hazard_stage
// Directed bench for ifid_hazard_stage, built with CNT_W=4 so the counter can
// be driven into saturation. Inputs change 1 time unit after a rising edge.
// Outputs are sampled at the same point.
// ----------------------------------------------------------------------------
module tb_ifid_hazard_stage;

  localparam int          CNT_W   = 4;
  localparam logic [31:0] NOP     = 32'h00000013;
  localparam logic [31:0] ADDI_X1 = 32'h00500093;  // addi x1,x0,5
  localparam logic [31:0] ADD_321 = 32'h002081B3;  // add  x3,x1,x2
  localparam logic [31:0] ADDI_RS = 32'h00208193;  // addi x3,x1,2 (rs2 field = 2)
  localparam logic [31:0] LUI_X1  = 32'h000120B7;  // lui  x1,0x12 (rs1 field = 2)

  logic clk;
  logic reset;

  int vectors;
  int miscompares;

  logic [63:0]      exp_pc;
  logic [63:0]      exp_ifid_pc;
  logic [CNT_W-1:0] exp_cnt;

  ifid_hazard_stage_if #(.CNT_W(CNT_W)) bus ();

  ifid_hazard_stage #(
    .PC_RESET (64'h0),
    .NOP_INSTR(NOP),
    .CNT_W    (CNT_W)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset                = 1'b0;
    bus.instr_in         = ADDI_X1;
    bus.branch_taken     = 1'b0;
    bus.branch_target    = 64'h0;
    bus.idex_MemRead     = 1'b0;
    bus.idex_rd          = 5'd0;
    step();
    step();
    vectors++;
    if (bus.PC_out !== 64'h0) begin
      miscompares++; $display("FAIL reset_pc: got %h expected %h", bus.PC_out, 64'h0);
    end
    vectors++;
    if (bus.ifid_instr !== NOP) begin
      miscompares++; $display("FAIL reset_instr: got %h expected %h", bus.ifid_instr, NOP);
    end
    vectors++;
    if (bus.ifid_valid !== 1'b0 || bus.ifid_PC !== 64'h0 || bus.stall_count !== 4'h0) begin
      miscompares++;
      $display("FAIL reset_misc: valid=%b pc=%h cnt=%h expected 0/0/0",
               bus.ifid_valid, bus.ifid_PC, bus.stall_count);
    end
    reset = 1'b1;
    step(); step(); step();
    vectors++;
    if (bus.PC_out !== 64'd12 || bus.ifid_PC !== 64'd8 || bus.ifid_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL release_fetch: pc=%0d ifid_pc=%0d valid=%b expected 12/8/1",
               bus.PC_out, bus.ifid_PC, bus.ifid_valid);
    end
    exp_pc  = 64'd12;
    exp_cnt = '0;
  endtask

  task automatic test_load_use();
    bus.instr_in = ADD_321;
    step();
    exp_ifid_pc = exp_pc;
    exp_pc      = exp_pc + 64'd4;
    bus.idex_MemRead = 1'b1;
    bus.idex_rd      = 5'd2;
    #1;
    vectors++;
    if (bus.stall !== 1'b1) begin
      miscompares++; $display("FAIL lu_stall: got %b expected 1", bus.stall);
    end
    step();
    exp_cnt++;
    vectors++;
    if (bus.PC_out !== exp_pc || bus.ifid_PC !== exp_ifid_pc || bus.ifid_instr !== ADD_321) begin
      miscompares++;
      $display("FAIL lu_hold: pc=%h ifid_pc=%h instr=%h expected %h/%h/%h",
               bus.PC_out, bus.ifid_PC, bus.ifid_instr, exp_pc, exp_ifid_pc, ADD_321);
    end
    vectors++;
    if (bus.stall_count !== exp_cnt) begin
      miscompares++; $display("FAIL lu_count: got %h expected %h", bus.stall_count, exp_cnt);
    end
    bus.idex_MemRead = 1'b0;
    #1;
    vectors++;
    if (bus.stall !== 1'b0) begin
      miscompares++; $display("FAIL lu_bubble_stall: got %b expected 0", bus.stall);
    end
    step();
    exp_ifid_pc = exp_pc;
    exp_pc      = exp_pc + 64'd4;
    vectors++;
    if (bus.PC_out !== exp_pc || bus.ifid_PC !== exp_ifid_pc) begin
      miscompares++;
      $display("FAIL lu_resume: pc=%h ifid_pc=%h expected %h/%h",
               bus.PC_out, bus.ifid_PC, exp_pc, exp_ifid_pc);
    end
  endtask

  task automatic test_no_hazard();
    // IF/ID still holds add x3,x1,x2.
    bus.idex_MemRead = 1'b1; bus.idex_rd = 5'd0; #1;
    vectors++;
    if (bus.stall !== 1'b0) begin
      miscompares++; $display("FAIL nh_rd0: got %b expected 0", bus.stall);
    end
    bus.idex_MemRead = 1'b0; bus.idex_rd = 5'd2; #1;
    vectors++;
    if (bus.stall !== 1'b0) begin
      miscompares++; $display("FAIL nh_nomem: got %b expected 0", bus.stall);
    end
    bus.idex_MemRead = 1'b1; bus.idex_rd = 5'd1; #1;
    vectors++;
    if (bus.stall !== 1'b1) begin
      miscompares++; $display("FAIL nh_rs1_match: got %b expected 1", bus.stall);
    end
    // I-type: the rs2 field matches but is not a source register.
    bus.idex_MemRead = 1'b0; bus.instr_in = ADDI_RS;
    step();
    exp_ifid_pc = exp_pc; exp_pc = exp_pc + 64'd4;
    bus.idex_MemRead = 1'b1; bus.idex_rd = 5'd2; #1;
    vectors++;
    if (bus.stall !== 1'b0) begin
      miscompares++; $display("FAIL nh_itype_rs2: got %b expected 0", bus.stall);
    end
    // LUI: the rs1 field matches but is not a source register.
    bus.idex_MemRead = 1'b0; bus.instr_in = LUI_X1;
    step();
    exp_ifid_pc = exp_pc; exp_pc = exp_pc + 64'd4;
    bus.idex_MemRead = 1'b1; bus.idex_rd = 5'd2; #1;
    vectors++;
    if (bus.stall !== 1'b0) begin
      miscompares++; $display("FAIL nh_lui_rd2: got %b expected 0", bus.stall);
    end
    bus.idex_rd = 5'd0;
    step();
    exp_ifid_pc = exp_pc; exp_pc = exp_pc + 64'd4;
    vectors++;
    if (bus.PC_out !== exp_pc || bus.ifid_PC !== exp_ifid_pc || bus.stall_count !== exp_cnt) begin
      miscompares++;
      $display("FAIL nh_advance: pc=%h ifid_pc=%h cnt=%h expected %h/%h/%h",
               bus.PC_out, bus.ifid_PC, bus.stall_count, exp_pc, exp_ifid_pc, exp_cnt);
    end
  endtask

  task automatic test_branch_flush();
    bus.idex_MemRead = 1'b0; bus.instr_in = ADD_321;
    step();
    bus.idex_MemRead  = 1'b1; bus.idex_rd = 5'd2;
    bus.branch_taken  = 1'b1; bus.branch_target = 64'h103;
    #1;
    vectors++;
    if (bus.stall !== 1'b0 || bus.flush !== 1'b1) begin
      miscompares++;
      $display("FAIL br_decode: stall=%b flush=%b expected 0/1", bus.stall, bus.flush);
    end
    step();
    vectors++;
    if (bus.PC_out !== 64'h100 || bus.ifid_instr !== NOP || bus.ifid_valid !== 1'b0 ||
        bus.ifid_PC !== 64'h0) begin
      miscompares++;
      $display("FAIL br_redirect: pc=%h instr=%h valid=%b ifid_pc=%h expected 100/%h/0/0",
               bus.PC_out, bus.ifid_instr, bus.ifid_valid, bus.ifid_PC, NOP);
    end
    vectors++;
    if (bus.stall_count !== exp_cnt) begin
      miscompares++; $display("FAIL br_count: got %h expected %h", bus.stall_count, exp_cnt);
    end
    bus.branch_taken = 1'b0; bus.instr_in = ADDI_X1; #1;
    vectors++;
    if (bus.stall !== 1'b0 || bus.flush !== 1'b0) begin
      miscompares++;
      $display("FAIL br_after_stall: stall=%b flush=%b expected 0/0", bus.stall, bus.flush);
    end
    step();
    vectors++;
    if (bus.PC_out !== 64'h104 || bus.ifid_PC !== 64'h100 || bus.ifid_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL br_refetch: pc=%h ifid_pc=%h valid=%b expected 104/100/1",
               bus.PC_out, bus.ifid_PC, bus.ifid_valid);
    end
    // Redirect to the last word of the address space, then wrap to zero.
    bus.idex_MemRead = 1'b0;
    bus.branch_taken = 1'b1; bus.branch_target = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    bus.branch_taken = 1'b0;
    vectors++;
    if (bus.PC_out !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      miscompares++;
      $display("FAIL br_align: got %h expected %h", bus.PC_out, 64'hFFFF_FFFF_FFFF_FFFC);
    end
    step();
    vectors++;
    if (bus.PC_out !== 64'h0 || bus.ifid_PC !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      miscompares++;
      $display("FAIL pc_wrap: pc=%h ifid_pc=%h expected 0/fffffffffffffffc",
               bus.PC_out, bus.ifid_PC);
    end
    exp_pc = 64'h0;
  endtask

  task automatic test_saturation();
    bus.idex_MemRead = 1'b0; bus.instr_in = ADD_321;
    step();
    exp_pc = exp_pc + 64'd4;
    bus.idex_MemRead = 1'b1; bus.idex_rd = 5'd2;
    for (int i = 0; i < 20; i++) begin
      step();
      if (exp_cnt != 4'hF) exp_cnt++;
      vectors++;
      if (bus.stall_count !== exp_cnt) begin
        miscompares++;
        $display("FAIL sat_count[%0d]: got %h expected %h", i, bus.stall_count, exp_cnt);
      end
    end
    vectors++;
    if (bus.stall_count !== 4'hF || bus.PC_out !== exp_pc || bus.stall !== 1'b1) begin
      miscompares++;
      $display("FAIL sat_hold: cnt=%h pc=%h stall=%b expected f/%h/1",
               bus.stall_count, bus.PC_out, bus.stall, exp_pc);
    end
  endtask

  task automatic test_reset_mid_stall();
    // The load-use hazard from the previous test is still present.
    reset = 1'b0;
    step();
    vectors++;
    if (bus.PC_out !== 64'h0 || bus.ifid_instr !== NOP || bus.ifid_valid !== 1'b0 ||
        bus.ifid_PC !== 64'h0 || bus.stall_count !== 4'h0) begin
      miscompares++;
      $display("FAIL rst_stall_state: pc=%h instr=%h valid=%b ifid_pc=%h cnt=%h expected reset values",
               bus.PC_out, bus.ifid_instr, bus.ifid_valid, bus.ifid_PC, bus.stall_count);
    end
    reset = 1'b1; #1;
    vectors++;
    if (bus.stall !== 1'b0) begin
      miscompares++; $display("FAIL rst_release_stall: got %b expected 0", bus.stall);
    end
    step();
    vectors++;
    if (bus.PC_out !== 64'd4 || bus.ifid_PC !== 64'h0 || bus.ifid_instr !== ADD_321 ||
        bus.ifid_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_refetch: pc=%h ifid_pc=%h instr=%h valid=%b expected 4/0/%h/1",
               bus.PC_out, bus.ifid_PC, bus.ifid_instr, bus.ifid_valid, ADD_321);
    end
    vectors++;
    if (bus.stall !== 1'b1) begin
      miscompares++; $display("FAIL rst_hazard_again: got %b expected 1", bus.stall);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_load_use();
    test_no_hazard();
    test_branch_flush();
    test_saturation();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
